// File: rtl/seq_match_ctrl.sv
// Serial pattern matcher: arms on start, hunts for a programmable bit pattern and
// counts matches up to a target. Optional hunt timeout when SEQ_MATCH_TIMEOUT_EN is defined.
module seq_match_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               in,
   input  logic               in_valid,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [4:0]         cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic               start,
   input  logic               abort,
`ifdef SEQ_MATCH_TIMEOUT_EN
   input  logic [15:0]        cfg_timeout,
   output logic               timeout,
`endif
   output logic               busy,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               done,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

   state_t             state_q, state_n;
   logic [MAX_LEN-1:0] pat_q;
   logic [4:0]         len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [4:0]         bits_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               match_q;

   logic [MAX_LEN-1:0] hist_shift;
   logic [4:0]         bits_inc;
   logic [MAX_LEN-1:0] mask;
   logic               hit;
   logic               target_hit;
   logic               arm;
   logic               shift;
   logic               count;

`ifdef SEQ_MATCH_TIMEOUT_EN
   logic [15:0] tmo_q;
   logic [15:0] tcnt_q;
   logic        timeout_q;
   logic        tmo_fire;
`endif

   function automatic logic [4:0] clamp_len(input logic [4:0] l);
      if (l <= 5'd1)
         return 5'd1;
      else if (l > MAX_LEN_L)
         return MAX_LEN_L;
      else
         return l;
   endfunction

   // Candidate history/bit count as if the current bit were accepted.
   assign hist_shift = {hist_q[MAX_LEN-2:0], in};
   assign bits_inc   = (bits_q >= MAX_LEN_L) ? bits_q : bits_q + 5'd1;
   assign mask       = ~({MAX_LEN{1'b1}} << len_q);
   assign hit        = (bits_inc >= len_q) && (((hist_shift ^ pat_q) & mask) == '0);
   assign target_hit = (tgt_q != '0) && (cnt_q == tgt_q);

   always_ff @(posedge clk) begin
      if (!resetn)
         state_q <= IDLE;
      else
         state_q <= state_n;
   end

   // Handshake: start is a level request taken only in IDLE; abort wins over everything.
   always_comb begin
      state_n = state_q;
      arm     = 1'b0;
      shift   = 1'b0;
      count   = 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
      tmo_fire = 1'b0;
`endif
      if (abort) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  arm     = 1'b1;
                  state_n = HUNT;
               end
            end
            HUNT: begin
               // Target reached on the previous edge: leave without sampling further bits.
               if (target_hit) begin
                  state_n = DONE;
               end else begin
                  if (in_valid) begin
                     shift = 1'b1;
                     count = hit;
                  end
`ifdef SEQ_MATCH_TIMEOUT_EN
                  if (!count && (tmo_q != 16'd0) &&
                      (({1'b0, tcnt_q} + 17'd1) == {1'b0, tmo_q})) begin
                     tmo_fire = 1'b1;
                     state_n  = IDLE;
                  end
`endif
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pat_q   <= '0;
         len_q   <= 5'd0;
         ovl_q   <= 1'b0;
         tgt_q   <= '0;
         hist_q  <= '0;
         bits_q  <= 5'd0;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         match_q <= count;
         if (arm) begin
            pat_q  <= cfg_pattern;
            len_q  <= clamp_len(cfg_len);
            ovl_q  <= cfg_overlap;
            tgt_q  <= cfg_target;
            hist_q <= '0;
            bits_q <= 5'd0;
            cnt_q  <= '0;
         end else if (shift) begin
            hist_q <= hist_shift;
            bits_q <= (count && !ovl_q) ? 5'd0 : bits_inc;
            if (count && (cnt_q != {CNT_W{1'b1}}))
               cnt_q <= cnt_q + 1'b1;
         end
      end
   end

`ifdef SEQ_MATCH_TIMEOUT_EN
   // Idle-hunt counter restarts on arm and on every counted match.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tmo_q     <= 16'd0;
         tcnt_q    <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_fire;
         if (arm) begin
            tmo_q  <= cfg_timeout;
            tcnt_q <= 16'd0;
         end else if ((state_q == HUNT) && !abort) begin
            tcnt_q <= count ? 16'd0 : tcnt_q + 16'd1;
         end
      end
   end

   assign timeout = timeout_q;
`endif

   assign busy      = (state_q == HUNT);
   assign done      = (state_q == DONE);
   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: per-cycle vector table with hand-computed outputs,
// plus hand sequences for counter saturation and (when enabled) the hunt timeout.
module tb_seq_match_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       in;
   logic       in_valid;
   logic [7:0] cfg_pattern;
   logic [4:0] cfg_len;
   logic       cfg_overlap;
   logic [7:0] cfg_target;
   logic       start;
   logic       abort;
   logic       busy;
   logic       match;
   logic [7:0] match_cnt;
   logic       done;
   logic [1:0] dbg_state;
`ifdef SEQ_MATCH_TIMEOUT_EN
   logic [15:0] cfg_timeout;
   logic        timeout;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst_n;
      logic       st;
      logic       ab;
      logic       vld;
      logic       bit_in;
      logic [7:0] pat;
      logic [4:0] len;
      logic       ovl;
      logic [7:0] tgt;
      logic       e_busy;
      logic       e_match;
      logic       e_done;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   logic [7:0] cur_pat;
   logic [4:0] cur_len;
   logic       cur_ovl;
   logic [7:0] cur_tgt;

   seq_match_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .in          (in),
      .in_valid    (in_valid),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
`ifdef SEQ_MATCH_TIMEOUT_EN
      .cfg_timeout (cfg_timeout),
      .timeout     (timeout),
`endif
      .busy        (busy),
      .match       (match),
      .match_cnt   (match_cnt),
      .done        (done),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic s, input logic a, input logic vl, input logic b,
                      input logic eb, input logic em, input logic ed, input logic [7:0] ec);
      vec_t v;
      v.rst_n = r;  v.st = s;  v.ab = a;  v.vld = vl;  v.bit_in = b;
      v.pat = cur_pat;  v.len = cur_len;  v.ovl = cur_ovl;  v.tgt = cur_tgt;
      v.e_busy = eb;  v.e_match = em;  v.e_done = ed;  v.e_cnt = ec;
      vecs.push_back(v);
   endtask

   // Convenience: one valid data bit in HUNT with expected match/count.
   task automatic add_bit(input logic b, input logic em, input logic [7:0] ec);
      add(1, 0, 0, 1, b, 1, em, 0, ec);
   endtask

   task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0b expected %0b", name, idx, act, exp);
      end
   endtask

   task automatic check_cnt(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0;  in = 1'b0;  in_valid = 1'b0;  start = 1'b0;  abort = 1'b0;
      cfg_pattern = 8'h00;  cfg_len = 5'd0;  cfg_overlap = 1'b0;  cfg_target = 8'd0;
`ifdef SEQ_MATCH_TIMEOUT_EN
      cfg_timeout = 16'd0;
`endif

      // Overlapping 1001 hunt, target 0
      cur_pat = 8'b0000_1001;  cur_len = 5'd4;  cur_ovl = 1'b1;  cur_tgt = 8'd0;
      add(0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(1, 1, 8'd1);
      add_bit(0, 0, 8'd1);  add_bit(0, 0, 8'd1);  add_bit(1, 1, 8'd2);
      add(1, 0, 0, 0, 0, 1, 0, 0, 8'd2);
      add(1, 0, 1, 0, 0, 0, 0, 0, 8'd2);
      add(1, 0, 0, 1, 1, 0, 0, 0, 8'd2);

      // Non-overlapping; a mid-hunt start with overlap=1 must be ignored
      cur_ovl = 1'b0;
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(1, 1, 8'd1);
      cur_ovl = 1'b1;
      add(1, 1, 0, 1, 0, 1, 0, 0, 8'd1);
      cur_ovl = 1'b0;
      add_bit(0, 0, 8'd1);  add_bit(1, 0, 8'd1);
      add(1, 0, 1, 0, 0, 0, 0, 0, 8'd1);

      // Valid gaps (with in=1 on the bus) between bits 2 and 3
      cur_ovl = 1'b1;
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);
      add(1, 0, 0, 0, 1, 1, 0, 0, 8'd0);
      add(1, 0, 0, 0, 1, 1, 0, 0, 8'd0);
      add(1, 0, 0, 0, 1, 1, 0, 0, 8'd0);
      add_bit(0, 0, 8'd0);  add_bit(1, 1, 8'd1);
      add_bit(0, 0, 8'd1);  add_bit(0, 0, 8'd1);  add_bit(1, 1, 8'd2);
      add(1, 0, 1, 0, 0, 0, 0, 0, 8'd2);

      // Target 2: done one cycle after second match, then bits ignored
      cur_tgt = 8'd2;
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(1, 1, 8'd1);
      add_bit(0, 0, 8'd1);  add_bit(0, 0, 8'd1);  add_bit(1, 1, 8'd2);
      add(1, 0, 0, 1, 1, 0, 0, 1, 8'd2);
      add(1, 0, 0, 1, 0, 0, 0, 0, 8'd2);
      add(1, 0, 0, 1, 1, 0, 0, 0, 8'd2);

      // Abort on the completing bit; then abort beats start in IDLE
      cur_tgt = 8'd0;
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(0, 0, 8'd0);
      add(1, 0, 1, 1, 1, 0, 0, 0, 8'd0);
      add(1, 0, 0, 1, 1, 0, 0, 0, 8'd0);
      add(1, 1, 1, 0, 0, 0, 0, 0, 8'd0);

      // Reset in the middle of a hunt, on the completing bit
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(1, 1, 8'd1);
      add_bit(0, 0, 8'd1);  add_bit(0, 0, 8'd1);
      add(0, 0, 0, 1, 1, 0, 0, 0, 8'd0);
      add(1, 0, 0, 1, 1, 0, 0, 0, 8'd0);

      // Length 0 clamps to 1
      cur_pat = 8'h01;  cur_len = 5'd0;  cur_ovl = 1'b1;
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 1, 8'd1);  add_bit(0, 0, 8'd1);  add_bit(1, 1, 8'd2);
      add(1, 0, 1, 0, 0, 0, 0, 0, 8'd2);

      // Length 20 clamps to 8
      cur_pat = 8'hA5;  cur_len = 5'd20;  cur_ovl = 1'b0;
      add(1, 1, 0, 0, 0, 1, 0, 0, 8'd0);
      add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);
      add_bit(0, 0, 8'd0);  add_bit(1, 0, 8'd0);  add_bit(0, 0, 8'd0);  add_bit(1, 1, 8'd1);
      add(1, 0, 1, 0, 0, 0, 0, 0, 8'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         resetn = vecs[i].rst_n;  start = vecs[i].st;  abort = vecs[i].ab;
         in_valid = vecs[i].vld;  in = vecs[i].bit_in;
         cfg_pattern = vecs[i].pat;  cfg_len = vecs[i].len;
         cfg_overlap = vecs[i].ovl;  cfg_target = vecs[i].tgt;
         tick();
         check_bit("busy", i, busy, vecs[i].e_busy);
         check_bit("match", i, match, vecs[i].e_match);
         check_bit("done", i, done, vecs[i].e_done);
         check_cnt("match_cnt", i, match_cnt, vecs[i].e_cnt);
      end

      // Count saturation: len-1 pattern '1', 260 consecutive ones
      resetn = 1'b1;  abort = 1'b0;  start = 1'b1;  in_valid = 1'b0;
      cfg_pattern = 8'h01;  cfg_len = 5'd1;  cfg_overlap = 1'b1;  cfg_target = 8'd0;
      tick();
      start = 1'b0;  in_valid = 1'b1;  in = 1'b1;
      for (int k = 0; k < 260; k++) tick();
      check_cnt("sat_cnt", 0, match_cnt, 8'hFF);
      check_bit("sat_match", 0, match, 1'b1);
      check_bit("sat_busy", 0, busy, 1'b1);
      in_valid = 1'b0;  abort = 1'b1;
      tick();
      abort = 1'b0;
      check_cnt("sat_hold", 0, match_cnt, 8'hFF);
      check_bit("sat_idle", 0, busy, 1'b0);

`ifdef SEQ_MATCH_TIMEOUT_EN
      // Timeout of 5 hunt cycles with an all-zero stream
      cfg_pattern = 8'b0000_1001;  cfg_len = 5'd4;  cfg_timeout = 16'd5;  start = 1'b1;
      tick();
      start = 1'b0;  in_valid = 1'b1;  in = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_bit("tmo_early", k, timeout, 1'b0);
         check_bit("tmo_busy", k, busy, 1'b1);
      end
      tick();
      check_bit("tmo_pulse", 5, timeout, 1'b1);
      check_bit("tmo_idle", 5, busy, 1'b0);
      tick();
      check_bit("tmo_clear", 6, timeout, 1'b0);
      in_valid = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
